// File: rtl/sinc3_decim_ctrl.sv
// Sequencer for the sinc3 decimation datapath: integrator gating, decimation tick,
// flush-and-settle on start or ratio change, and a valid/ready output handshake.
module sinc3_decim_ctrl #(
  parameter int CNT_W        = 16,
  parameter int SETTLE_WORDS = 3,
  parameter int DEF_RATIO    = 256
) (
  input  logic             mclk1,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] cfg_ratio,
  input  logic             out_ready,
  input  logic             ovr_clr,
  output logic             acc_en,
  output logic             filt_clr,
  output logic             word_tick,
  output logic             capture,
  output logic             data_valid,
  output logic             overrun,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] phase
);

  localparam int SC_W = (SETTLE_WORDS < 2) ? 1 : $clog2(SETTLE_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] ratio_r;
  logic [CNT_W-1:0] phase_r;
  logic [SC_W-1:0]  settle_cnt_r;
  logic             acc_en_r;
  logic             filt_clr_r;
  logic             word_tick_r;
  logic             capture_r;
  logic             data_valid_r;
  logic             overrun_r;

  logic [CNT_W-1:0] ratio_clamped_s;
  logic [CNT_W-1:0] last_phase_s;
  logic [CNT_W-1:0] phase_step_s;
  logic             ovr_set_s;
  logic             ovr_nxt_s;

  // Next-phase, clamped ratio and overrun set/clear arbitration.
  always_comb begin
    ratio_clamped_s = cfg_ratio;
    last_phase_s    = ratio_r - {{(CNT_W-1){1'b0}}, 1'b1};
    phase_step_s    = phase_r + {{(CNT_W-1){1'b0}}, 1'b1};
    ovr_set_s       = 1'b0;
    ovr_nxt_s       = overrun_r;
    if (cfg_ratio < CNT_W'(2)) begin
      ratio_clamped_s = CNT_W'(2);
    end else begin
      ratio_clamped_s = cfg_ratio;
    end
    if (phase_r == last_phase_s) begin
      phase_step_s = '0;
    end else begin
      phase_step_s = phase_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    // A word is lost only when it is replaced in RUN without being accepted.
    if (enable && !cfg_load && (state_r == RUN) && capture_r && data_valid_r && !out_ready) begin
      ovr_set_s = 1'b1;
    end else begin
      ovr_set_s = 1'b0;
    end
    if (ovr_set_s) begin
      ovr_nxt_s = 1'b1;
    end else if (ovr_clr) begin
      ovr_nxt_s = 1'b0;
    end else begin
      ovr_nxt_s = overrun_r;
    end
  end

  // Sequencer state, phase counter and all registered strobes.
  always_ff @(posedge mclk1) begin
    if (reset) begin
      state_r      <= IDLE;
      ratio_r      <= CNT_W'(DEF_RATIO);
      phase_r      <= '0;
      settle_cnt_r <= '0;
      acc_en_r     <= 1'b0;
      filt_clr_r   <= 1'b0;
      word_tick_r  <= 1'b0;
      capture_r    <= 1'b0;
      data_valid_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      overrun_r <= ovr_nxt_s;
      if (cfg_load) begin
        ratio_r <= ratio_clamped_s;
      end
      if (!enable) begin
        state_r      <= IDLE;
        phase_r      <= '0;
        settle_cnt_r <= '0;
        acc_en_r     <= 1'b0;
        filt_clr_r   <= 1'b0;
        word_tick_r  <= 1'b0;
        capture_r    <= 1'b0;
        data_valid_r <= 1'b0;
      end else if (cfg_load || (state_r == IDLE)) begin
        // Start or ratio change: flush the filter and settle from scratch.
        state_r      <= SETTLE;
        phase_r      <= '0;
        settle_cnt_r <= '0;
        acc_en_r     <= 1'b1;
        filt_clr_r   <= 1'b1;
        word_tick_r  <= 1'b0;
        capture_r    <= 1'b0;
        data_valid_r <= 1'b0;
      end else begin
        acc_en_r    <= 1'b1;
        filt_clr_r  <= 1'b0;
        phase_r     <= phase_step_s;
        word_tick_r <= (phase_step_s == last_phase_s);
        capture_r   <= word_tick_r;
        if ((state_r == SETTLE) && capture_r) begin
          settle_cnt_r <= settle_cnt_r + SC_W'(1);
          if (settle_cnt_r + SC_W'(1) == SC_W'(SETTLE_WORDS)) begin
            state_r <= RUN;
          end
        end
        if ((state_r == RUN) && capture_r) begin
          data_valid_r <= 1'b1;
        end else if (data_valid_r && out_ready) begin
          data_valid_r <= 1'b0;
        end
      end
    end
  end

  assign acc_en     = acc_en_r;
  assign filt_clr   = filt_clr_r;
  assign word_tick  = word_tick_r;
  assign capture    = capture_r;
  assign data_valid = data_valid_r;
  assign overrun    = overrun_r;
  assign state      = state_r;
  assign phase      = phase_r;

endmodule

// File: tb/tb_sinc3_decim_ctrl.sv
// Directed bench for sinc3_decim_ctrl: a cycle-by-cycle vector table at M=4 plus
// hand-written sequences for default ratio, reconfiguration, clamping, abort and reset.
module tb_sinc3_decim_ctrl;

  logic        mclk1 = 1'b0;
  logic        reset;
  logic        enable;
  logic        cfg_load;
  logic [15:0] cfg_ratio;
  logic        out_ready;
  logic        ovr_clr;
  logic        acc_en;
  logic        filt_clr;
  logic        word_tick;
  logic        capture;
  logic        data_valid;
  logic        overrun;
  logic [1:0]  state;
  logic [15:0] phase;
  logic [23:0] obs;

  int checks = 0;
  int errors = 0;
  int n;

  typedef struct {
    logic        en;
    logic        rdy;
    logic        clr;
    logic [23:0] want;
  } vec_t;

  vec_t tbl[$];

  sinc3_decim_ctrl #(.CNT_W(16), .SETTLE_WORDS(3), .DEF_RATIO(256)) dut (
    .mclk1(mclk1), .reset(reset), .enable(enable), .cfg_load(cfg_load),
    .cfg_ratio(cfg_ratio), .out_ready(out_ready), .ovr_clr(ovr_clr),
    .acc_en(acc_en), .filt_clr(filt_clr), .word_tick(word_tick), .capture(capture),
    .data_valid(data_valid), .overrun(overrun), .state(state), .phase(phase)
  );

  always #5 mclk1 = ~mclk1;

  assign obs = {acc_en, filt_clr, word_tick, capture, data_valid, overrun, state, phase};

  function automatic logic [23:0] pk(input logic acc, fc, wt, cap, dv, ov,
                                     input logic [1:0] st, input logic [15:0] ph);
    return {acc, fc, wt, cap, dv, ov, st, ph};
  endfunction

  function automatic vec_t v(input logic en, rdy, clr, acc, fc, wt, cap, dv, ov,
                             input logic [1:0] st, input logic [15:0] ph);
    vec_t r;
    r.en   = en;
    r.rdy  = rdy;
    r.clr  = clr;
    r.want = pk(acc, fc, wt, cap, dv, ov, st, ph);
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic step();
    @(posedge mclk1);
    #1;
  endtask

  // Steps until word_tick is seen; returns the number of edges taken (bounded).
  task automatic count_tick(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!word_tick && cnt < 2000);
  endtask

  initial begin
    // en rdy clr | acc fc wt cap dv ov st ph  (ratio 4, edge 1 samples enable)
    tbl.push_back(v(1,1,0, 1,1,0,0,0,0,1,0));  // 1
    tbl.push_back(v(1,1,0, 1,0,0,0,0,0,1,1));
    tbl.push_back(v(1,1,0, 1,0,0,0,0,0,1,2));
    tbl.push_back(v(1,1,0, 1,0,1,0,0,0,1,3));  // 4 tick
    tbl.push_back(v(1,1,0, 1,0,0,1,0,0,1,0));
    tbl.push_back(v(1,1,0, 1,0,0,0,0,0,1,1));
    tbl.push_back(v(1,1,0, 1,0,0,0,0,0,1,2));
    tbl.push_back(v(1,1,0, 1,0,1,0,0,0,1,3));  // 8
    tbl.push_back(v(1,1,0, 1,0,0,1,0,0,1,0));
    tbl.push_back(v(1,1,0, 1,0,0,0,0,0,1,1));
    tbl.push_back(v(1,1,0, 1,0,0,0,0,0,1,2));
    tbl.push_back(v(1,1,0, 1,0,1,0,0,0,1,3));  // 12
    tbl.push_back(v(1,1,0, 1,0,0,1,0,0,1,0));  // 13 third settle capture
    tbl.push_back(v(1,1,0, 1,0,0,0,0,0,2,1));  // 14 RUN
    tbl.push_back(v(1,1,0, 1,0,0,0,0,0,2,2));
    tbl.push_back(v(1,1,0, 1,0,1,0,0,0,2,3));  // 16
    tbl.push_back(v(1,1,0, 1,0,0,1,0,0,2,0));
    tbl.push_back(v(1,1,0, 1,0,0,0,1,0,2,1));  // 18 first data_valid
    tbl.push_back(v(1,1,0, 1,0,0,0,0,0,2,2));
    tbl.push_back(v(1,1,0, 1,0,1,0,0,0,2,3));
    tbl.push_back(v(1,1,0, 1,0,0,1,0,0,2,0));
    tbl.push_back(v(1,1,0, 1,0,0,0,1,0,2,1));
    tbl.push_back(v(1,1,0, 1,0,0,0,0,0,2,2));  // 23
    tbl.push_back(v(1,0,0, 1,0,1,0,0,0,2,3));  // 24 consumer stalls
    tbl.push_back(v(1,0,0, 1,0,0,1,0,0,2,0));
    tbl.push_back(v(1,0,0, 1,0,0,0,1,0,2,1));
    tbl.push_back(v(1,0,0, 1,0,0,0,1,0,2,2));
    tbl.push_back(v(1,0,0, 1,0,1,0,1,0,2,3));
    tbl.push_back(v(1,0,0, 1,0,0,1,1,0,2,0));
    tbl.push_back(v(1,1,0, 1,0,0,0,1,0,2,1));  // 30 accept + capture together
    tbl.push_back(v(1,1,0, 1,0,0,0,0,0,2,2));
    tbl.push_back(v(1,0,0, 1,0,1,0,0,0,2,3));  // 32
    tbl.push_back(v(1,0,0, 1,0,0,1,0,0,2,0));
    tbl.push_back(v(1,0,0, 1,0,0,0,1,0,2,1));
    tbl.push_back(v(1,0,0, 1,0,0,0,1,0,2,2));
    tbl.push_back(v(1,0,0, 1,0,1,0,1,0,2,3));
    tbl.push_back(v(1,0,0, 1,0,0,1,1,0,2,0));
    tbl.push_back(v(1,0,0, 1,0,0,0,1,1,2,1));  // 38 overrun
    tbl.push_back(v(1,0,0, 1,0,0,0,1,1,2,2));
    tbl.push_back(v(1,0,0, 1,0,1,0,1,1,2,3));
    tbl.push_back(v(1,0,0, 1,0,0,1,1,1,2,0));
    tbl.push_back(v(1,0,1, 1,0,0,0,1,1,2,1));  // 42 set beats clear
    tbl.push_back(v(1,0,1, 1,0,0,0,1,0,2,2));  // 43 clear
    tbl.push_back(v(1,1,0, 1,0,1,0,0,0,2,3));
    tbl.push_back(v(1,1,0, 1,0,0,1,0,0,2,0));
    tbl.push_back(v(1,1,0, 1,0,0,0,1,0,2,1));
    tbl.push_back(v(1,1,0, 1,0,0,0,0,0,2,2));  // 47
    tbl.push_back(v(0,1,0, 0,0,0,0,0,0,0,0));  // 48 abort at phase 2
    tbl.push_back(v(0,1,0, 0,0,0,0,0,0,0,0));  // 49 no tick/capture leaks

    reset = 1'b1; enable = 1'b0; cfg_load = 1'b0; cfg_ratio = 16'd0;
    out_ready = 1'b0; ovr_clr = 1'b0;
    step();
    step();
    check("reset_state", {8'd0, obs}, 32'd0);
    reset = 1'b0;

    // Default ratio of 256 after reset.
    enable = 1'b1;
    step();
    check("def_enter", {8'd0, obs}, {8'd0, pk(1,1,0,0,0,0,2'd1,16'd0)});
    count_tick(n);
    check("def_first_tick", n, 32'd255);
    count_tick(n);
    check("def_tick_period", n, 32'd256);
    enable = 1'b0;
    step();
    cfg_load = 1'b1; cfg_ratio = 16'd4;
    step();
    check("load_idle", {8'd0, obs}, 32'd0);
    cfg_load = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      enable    = tbl[i].en;
      out_ready = tbl[i].rdy;
      ovr_clr   = tbl[i].clr;
      step();
      check($sformatf("vec%0d", i + 1), {8'd0, obs}, {8'd0, tbl[i].want});
    end
    ovr_clr = 1'b0;

    // Reconfigure mid-run to M=8.
    enable = 1'b1; out_ready = 1'b0;
    repeat (20) step();
    check("pre_reconf", {30'd0, state}, 32'd2);
    check("pre_reconf_dv", {31'd0, data_valid}, 32'd1);
    cfg_load = 1'b1; cfg_ratio = 16'd8;
    step();
    check("reconf_load", {8'd0, obs}, {8'd0, pk(1,1,0,0,0,0,2'd1,16'd0)});
    cfg_load = 1'b0;
    count_tick(n);
    check("reconf_first_tick", n, 32'd7);
    count_tick(n);
    check("reconf_period", n, 32'd8);
    step();
    check("capture_follows_tick", {31'd0, capture}, 32'd1);

    // Ratio 1 clamps to 2.
    cfg_load = 1'b1; cfg_ratio = 16'd1;
    step();
    cfg_load = 1'b0;
    check("clamp_load", {8'd0, obs}, {8'd0, pk(1,1,0,0,0,0,2'd1,16'd0)});
    count_tick(n);
    check("clamp_first_tick", n, 32'd1);
    count_tick(n);
    check("clamp_period", n, 32'd2);

    // Load together with enable=0: ratio latched, no flush.
    cfg_load = 1'b1; cfg_ratio = 16'd4; enable = 1'b0;
    step();
    check("load_abort", {8'd0, obs}, 32'd0);
    cfg_load = 1'b0; enable = 1'b1;
    step();
    count_tick(n);
    check("latched_ratio", n, 32'd3);

    // Reset in the middle of settling restores every output and the default ratio.
    step();
    step();
    reset = 1'b1;
    step();
    check("reset_mid_settle", {8'd0, obs}, 32'd0);
    reset = 1'b0;
    step();
    count_tick(n);
    check("reset_ratio", n, 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
